pulse_period_checker: RTL and testbench

//  Receive-side monitor for the periodic single-cycle tick produced by our tick generators.

---
 rtl/pulse_period_checker_if.sv | 26 ++
 rtl/pulse_period_checker.sv | 144 ++++++++++++++
 tb/tb_pulse_period_checker.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/pulse_period_checker_if.sv
// Bus bundle for pulse_period_checker: control/tick inputs and status outputs.
interface pulse_period_checker_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic             clr;
    logic             pulse_i;
    logic             locked;
    logic             period_vld;
    logic [CNT_W-1:0] period_o;
    logic             err_early;
    logic             err_late;
    logic [15:0]      err_cnt;

    // Side that drives the tick and control (tick source / supervisor)
    modport master (
        output en, clr, pulse_i,
        input  locked, period_vld, period_o, err_early, err_late, err_cnt
    );

    // Side that monitors the tick (the checker itself)
    modport slave (
        input  en, clr, pulse_i,
        output locked, period_vld, period_o, err_early, err_late, err_cnt
    );
endinterface

// File: rtl/pulse_period_checker.sv
// Receive-side monitor for a periodic single-cycle tick. Measures the
// interval between rising edges of pulse_i, checks it against
// EXP_PERIOD +/- TOL, tracks lock with an IDLE/ACQ/LOCK state machine and
// keeps a saturating error count.
module pulse_period_checker #(
    parameter int EXP_PERIOD = 9,
    parameter int TOL        = 0,
    parameter int CNT_W      = 8,
    parameter int LOCK_CNT   = 3,
    parameter int LOSS_CNT   = 2
) (
    input  logic                   clk,
    input  logic                   rstn,
    pulse_period_checker_if.slave  bus
);
    localparam logic [CNT_W-1:0] WIN_LO  = CNT_W'(EXP_PERIOD - TOL);
    localparam logic [CNT_W-1:0] WIN_HI  = CNT_W'(EXP_PERIOD + TOL);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int BAD_W  = $clog2(LOSS_CNT + 1);

    typedef enum logic [1:0] {IDLE, ACQ, LOCK} state_t;

    state_t              state;
    logic                pulse_q;
    logic [CNT_W-1:0]    cnt;
    logic [GOOD_W-1:0]   good;
    logic [BAD_W-1:0]    bad;

    logic                tick_ev;
    logic                checking;
    logic                in_window;
    logic                too_early;
    logic                timeout;
    logic                good_hit;
    logic                bad_hit;
    logic                err_hit;
    logic [CNT_W-1:0]    cnt_inc;

    // Event decode and interval classification for the current cycle
    always_comb begin
        tick_ev   = bus.pulse_i & ~pulse_q;
        checking  = (state != IDLE);
        in_window = (cnt >= WIN_LO) && (cnt <= WIN_HI);
        too_early = (cnt < WIN_LO);
        timeout   = checking && !tick_ev && (cnt == WIN_HI);
        good_hit  = checking && tick_ev && in_window;
        bad_hit   = checking && (tick_ev ? !in_window : timeout);
        err_hit   = bus.en && checking && (tick_ev ? too_early : timeout);
        cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    end

    // Lock state machine, interval counter and all registered status outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= IDLE;
            pulse_q        <= 1'b0;
            cnt            <= '0;
            good           <= '0;
            bad            <= '0;
            bus.locked     <= 1'b0;
            bus.period_vld <= 1'b0;
            bus.period_o   <= '0;
            bus.err_early  <= 1'b0;
            bus.err_late   <= 1'b0;
            bus.err_cnt    <= '0;
        end else begin
            pulse_q        <= bus.pulse_i;
            bus.period_vld <= 1'b0;
            bus.err_early  <= 1'b0;
            bus.err_late   <= 1'b0;

            // clr has priority over an error counted in the same cycle
            if (bus.clr)
                bus.err_cnt <= '0;
            else if (err_hit && bus.err_cnt != 16'hFFFF)
                bus.err_cnt <= bus.err_cnt + 16'd1;

            if (!bus.en) begin
                state      <= IDLE;
                bus.locked <= 1'b0;
                cnt        <= '0;
                good       <= '0;
                bad        <= '0;
            end else begin
                // After a timeout the window restarts from 0 so a dead tick
                // stream reports late once every EXP_PERIOD+TOL+1 cycles.
                if (tick_ev)
                    cnt <= CNT_W'(1);
                else if (timeout)
                    cnt <= '0;
                else
                    cnt <= cnt_inc;

                if (checking && tick_ev) begin
                    bus.period_vld <= 1'b1;
                    bus.period_o   <= cnt;
                    bus.err_early  <= too_early;
                end
                if (timeout)
                    bus.err_late <= 1'b1;

                case (state)
                    IDLE: begin
                        if (tick_ev) begin
                            state <= ACQ;
                            good  <= '0;
                        end
                    end
                    ACQ: begin
                        if (good_hit) begin
                            if (good == GOOD_W'(LOCK_CNT - 1)) begin
                                state      <= LOCK;
                                bus.locked <= 1'b1;
                                bad        <= '0;
                            end else begin
                                good <= good + 1'b1;
                            end
                        end else if (bad_hit) begin
                            good <= '0;
                        end
                    end
                    LOCK: begin
                        if (good_hit) begin
                            bad <= '0;
                        end else if (bad_hit) begin
                            if (bad == BAD_W'(LOSS_CNT - 1)) begin
                                state      <= ACQ;
                                bus.locked <= 1'b0;
                                good       <= '0;
                            end else begin
                                bad <= bad + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state      <= IDLE;
                        bus.locked <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pulse_period_checker.sv
// Testbench for pulse_period_checker: directed scenarios plus randomized tick
// trains, compared cycle by cycle against a timestamp-based reference model.
module tb_pulse_period_checker;
    localparam int EXP_PERIOD = 9;
    localparam int TOL        = 0;
    localparam int CNT_W      = 8;
    localparam int LOCK_CNT   = 3;
    localparam int LOSS_CNT   = 2;
    localparam int WIN_LO     = EXP_PERIOD - TOL;
    localparam int WIN_HI     = EXP_PERIOD + TOL;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    pulse_period_checker_if #(.CNT_W(CNT_W)) bus ();

    pulse_period_checker #(
        .EXP_PERIOD(EXP_PERIOD), .TOL(TOL), .CNT_W(CNT_W),
        .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    // Reference model: the interval is the distance in clock edges from the
    // start of the current window; mode 0/1/2 = idle/acquiring/locked.
    int m_edge, m_start, m_mode, m_good, m_bad, m_pq;
    int m_locked, m_vld, m_per, m_early, m_late, m_errs;

    function automatic void model_reset();
        m_edge = 0; m_start = 1; m_mode = 0; m_good = 0; m_bad = 0; m_pq = 0;
        m_locked = 0; m_vld = 0; m_per = 0; m_early = 0; m_late = 0; m_errs = 0;
    endfunction

    function automatic void judge(input bit ok);
        if (m_mode == 1) begin
            if (ok) begin
                m_good++;
                if (m_good == LOCK_CNT) begin m_mode = 2; m_bad = 0; end
            end else m_good = 0;
        end else if (m_mode == 2) begin
            if (ok) m_bad = 0;
            else begin
                m_bad++;
                if (m_bad == LOSS_CNT) begin m_mode = 1; m_good = 0; end
            end
        end
    endfunction

    function automatic void model_step(input bit p, input bit e, input bit c);
        int interval;
        bit ev;
        m_edge++;
        interval = m_edge - m_start;
        if (interval > CNT_MAX) interval = CNT_MAX;
        ev = p && (m_pq == 0);
        m_pq = p;
        m_vld = 0; m_early = 0; m_late = 0;
        if (!e) begin
            m_mode = 0; m_good = 0; m_bad = 0; m_start = m_edge + 1;
        end else if (m_mode == 0) begin
            if (ev) begin m_mode = 1; m_good = 0; m_start = m_edge; end
        end else if (ev) begin
            m_start = m_edge;
            m_vld = 1;
            m_per = interval;
            m_early = (interval < WIN_LO);
            judge(interval >= WIN_LO && interval <= WIN_HI);
        end else if (interval == WIN_HI) begin
            m_late = 1;
            m_start = m_edge + 1;
            judge(1'b0);
        end
        if (c) m_errs = 0;
        else if ((m_early || m_late) && m_errs < 65535) m_errs++;
        m_locked = (m_mode == 2);
    endfunction

    task automatic compare_all();
        check("locked",     int'(bus.locked),     m_locked);
        check("period_vld", int'(bus.period_vld), m_vld);
        check("period_o",   int'(bus.period_o),   m_per);
        check("err_early",  int'(bus.err_early),  m_early);
        check("err_late",   int'(bus.err_late),   m_late);
        check("err_cnt",    int'(bus.err_cnt),    m_errs);
    endtask

    task automatic cycle(input bit p, input bit e, input bit c);
        @(negedge clk);
        bus.pulse_i = p;
        bus.en      = e;
        bus.clr     = c;
        model_step(p, e, c);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        bus.pulse_i = 1'b0;
        bus.en      = 1'b1;
        bus.clr     = 1'b0;
        rstn        = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // n ticks, each followed by period-width low cycles
    task automatic ticks(input int n, input int period, input int width, input bit rnd_clr);
        for (int i = 0; i < n; i++)
            for (int k = 0; k < period; k++)
                cycle(k < width, 1'b1, rnd_clr && ($urandom_range(0, 31) == 0));
    endtask

    initial begin
        bus.pulse_i = 1'b0;
        bus.en      = 1'b0;
        bus.clr     = 1'b0;
        rstn        = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        rstn = 1'b1;

        // Idle, then acquire on a clean 9-cycle stream
        repeat (4) cycle(1'b0, 1'b1, 1'b0);
        ticks(6, 9, 1, 1'b0);
        check("acq_locked", int'(bus.locked), 1);
        check("acq_errs",   int'(bus.err_cnt), 0);

        // One early interval of 7 while locked
        ticks(1, 7, 1, 1'b0);
        ticks(4, 9, 1, 1'b0);
        check("early_locked", int'(bus.locked), 1);
        check("early_errs",   int'(bus.err_cnt), 1);

        // Two intervals of 8 drop lock, further 9s relock
        ticks(2, 8, 1, 1'b0);
        ticks(5, 9, 1, 1'b0);
        check("relock_locked", int'(bus.locked), 1);
        check("relock_errs",   int'(bus.err_cnt), 3);

        // Tick stream stops
        repeat (45) cycle(1'b0, 1'b1, 1'b0);
        check("stop_locked", int'(bus.locked), 0);

        // Relock, then disable
        ticks(5, 9, 1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        check("dis_locked", int'(bus.locked), 0);
        repeat (3) cycle(1'b0, 1'b0, 1'b0);

        // Relock, then an early tick coincident with clr
        ticks(6, 9, 1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        repeat (6) cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1);
        check("clr_early",   int'(bus.err_early), 1);
        check("clr_errs",    int'(bus.err_cnt), 0);
        repeat (8) cycle(1'b0, 1'b1, 1'b0);

        // Wide ticks at 9-cycle rising-edge spacing
        ticks(7, 9, 5, 1'b0);
        check("wide_locked", int'(bus.locked), 1);

        // Mid-operation asynchronous reset
        apply_reset();

        // Randomized trains with occasional disables, clears and resets
        for (int it = 0; it < 250; it++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 3) apply_reset();
            else if (r < 8) repeat ($urandom_range(1, 4)) cycle($urandom_range(0, 1) == 1, 1'b0, 1'b0);
            else if (r < 15) repeat ($urandom_range(5, 25)) cycle(1'b0, 1'b1, 1'b0);
            else if (r < 55) ticks($urandom_range(1, 4), 9, $urandom_range(1, 5), 1'b1);
            else begin
                int per;
                per = $urandom_range(3, 13);
                ticks(1, per, $urandom_range(1, per - 1), 1'b1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
